rocket_scheduler: RTL and testbench
===================================

Name: rocket_scheduler

Overview:
- Frame-rate scheduler for player and alien rocket slots feeding the display priority mux.
- Each frame it decides whether a new player rocket and/or a new alien rocket launches, and which free slot each one uses.
- It tracks which slots are in flight, enforces the player fire cooldown and the alien fire period, and picks the shooting alien column pseudo-randomly.
- Rocket objects consume one-hot launch pulses plus a launch X coordinate; their drawing requests feed the priority mux.

Parameters:
- NUM_SLOTS, 3: rocket slots per side (player and alien).
- P_COOLDOWN, 8: minimum frames between player launches.
- A_PERIOD, 30: frames between alien fire attempts.
- NUM_COLS, 10: alien columns; alien_pick range is 0..NUM_COLS-1.
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-cycle pulse per video frame.
- game_enable, in, 1: high while the game runs.
- fire_btn, in, 1: debounced player fire level.
- player_x, in, 11: player ship X, sampled at player launch.
- alien_x, in, 11: X of the lowest live alien in column alien_pick, sampled at alien launch.
- p_done, in, NUM_SLOTS: per-slot pulse; player rocket hit something or left the screen.
- a_done, in, NUM_SLOTS: per-slot pulse; alien rocket hit something or left the screen.
- alien_pick, out, 4: requested shooter column.
- p_launch, out, NUM_SLOTS: one-hot, one-cycle player launch pulse.
- a_launch, out, NUM_SLOTS: one-hot, one-cycle alien launch pulse.
- launch_x, out, 11: X coordinate valid during any launch pulse.
- p_active, out, NUM_SLOTS: player slot in flight.
- a_active, out, NUM_SLOTS: alien slot in flight.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM IDLE, fire pending 0, cooldown 0.
  - Alien timer = A_PERIOD-1.
  - LFSR = LFSR_SEED.
  - fire_btn edge register 0.
- Fire edge: a 0->1 transition of fire_btn (registered compare) sets pending. Pending holds until served or game_enable=0. Further edges while pending are absorbed.
- FSM states IDLE -> P_CHECK -> A_CHECK -> IDLE:
  - IDLE leaves only on startOfFrame.
  - P_CHECK and A_CHECK each last exactly one cycle.
- Counters: on startOfFrame (in IDLE), cooldown decrements, saturating at 0.
- P_CHECK:
  - If pending, cooldown==0 and any p_active bit is 0:
    - p_launch <= one-hot of the lowest free index; that p_active bit <= 1.
    - launch_x <= player_x.
    - cooldown <= P_COOLDOWN; pending <= 0.
  - Otherwise no launch; pending is kept.
- A_CHECK:
  - LFSR advances once every A_CHECK. Polynomial x^8+x^6+x^5+x^4+1: shift left, bit0 = b7^b5^b4^b3.
  - If timer==0: timer <= A_PERIOD-1. If any a_active bit is 0: a_launch one-hot to the lowest free slot, that a_active bit <= 1, launch_x <= alien_x.
  - If timer!=0: timer decrements; no launch.
- alien_pick: registered, = lfsr[3:0] mod NUM_COLS (subtract NUM_COLS once when >= NUM_COLS). It is updated in P_CHECK, so alien_x is stable by A_CHECK.
- Launch pulses: 1 cycle wide, then 0. At most one p_launch and one a_launch per frame, never in the same cycle. launch_x holds its last value between launches.
- Slot release: p_done[i] / a_done[i] clears the active bit at the next edge, in any state.
  - done on an inactive slot is ignored.
  - Launch selection uses active bits as registered at the start of the cycle. A slot released in the same cycle is not reused until the next frame.
  - Multiple done bits in one cycle are all honoured.
- Full: all slots active -> no launch. Player pending is retained. The alien timer still reloads and that attempt is lost.
- game_enable=0 (synchronous, overrides all but reset):
  - Active bits, launches, pending and cooldown -> 0.
  - Timer -> A_PERIOD-1; FSM -> IDLE.
  - LFSR keeps running.
- Reset mid-frame: asynchronous return to reset values. No launch pulse may follow until the next full IDLE -> P_CHECK pass.

Test Plan:
- Reset release, game_enable=1, fire_btn 0->1 before frame 1, player_x=320 -> on the P_CHECK cycle after the first startOfFrame: p_launch=3'b001 for 1 cycle, launch_x=320, p_active=3'b001.
- fire_btn pressed every frame, no p_done -> launches at frames 1, 9, 17 (P_COOLDOWN=8) into slots 0, 1, 2. At frame 25, pending stays set and no launch (full). p_done[1] pulse -> next frame launches slot 1.
- p_done[0] and a P_CHECK in the same cycle with all slots full -> no launch that frame; slot 0 launched in the following frame.
- Alien timer from reset, alien_x=100 -> first a_launch=3'b001 at frame 30, then frame 60. Sequence of alien_pick values matches the LFSR model from seed 8'hA5 and is always <= 9.
- game_enable dropped with p_active=3'b111, a_active=3'b011, pending=1 -> next cycle all active 0, no pulses. Re-enable plus fire -> launch at slot 0 without cooldown wait.
- resetN asserted during A_CHECK with a launch due -> a_launch stays 0, all outputs 0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/rocket_scheduler.sv
// Per-frame launch scheduler for the player and alien rocket slots.
// It runs one short IDLE -> P_CHECK -> A_CHECK pass per frame and emits one-hot launch pulses with the launch X.
module rocket_scheduler #(
  parameter int         NUM_SLOTS  = 3,
  parameter int         P_COOLDOWN = 8,
  parameter int         A_PERIOD   = 30,
  parameter int         NUM_COLS   = 10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 game_enable,
  input  logic                 fire_btn,
  input  logic [10:0]          player_x,
  input  logic [10:0]          alien_x,
  input  logic [NUM_SLOTS-1:0] p_done,
  input  logic [NUM_SLOTS-1:0] a_done,
  output logic [3:0]           alien_pick,
  output logic [NUM_SLOTS-1:0] p_launch,
  output logic [NUM_SLOTS-1:0] a_launch,
  output logic [10:0]          launch_x,
  output logic [NUM_SLOTS-1:0] p_active,
  output logic [NUM_SLOTS-1:0] a_active
);

  localparam int         CD_W = $clog2(P_COOLDOWN + 1);
  localparam int         TM_W = (A_PERIOD > 1) ? $clog2(A_PERIOD) : 1;
  localparam logic [3:0] COLS = 4'(NUM_COLS);

  typedef enum logic [1:0] {IDLE, P_CHECK, A_CHECK} state_t;

  state_t               state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 fire_prev_q;
  logic [CD_W-1:0]      cooldown_q, cooldown_d;
  logic [TM_W-1:0]      timer_q, timer_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [3:0]           pick_q, pick_d;
  logic [NUM_SLOTS-1:0] p_active_q, p_active_d;
  logic [NUM_SLOTS-1:0] a_active_q, a_active_d;
  logic [NUM_SLOTS-1:0] p_launch_q, p_launch_d;
  logic [NUM_SLOTS-1:0] a_launch_q, a_launch_d;
  logic [10:0]          launch_x_q, launch_x_d;

  logic                 fire_edge;
  logic [NUM_SLOTS-1:0] p_pick_slot;
  logic [NUM_SLOTS-1:0] a_pick_slot;
  logic [3:0]           lfsr_low;
  logic [3:0]           pick_calc;

  // Isolates the lowest zero bit: invert, then keep the lowest set bit.
  function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] act);
    logic [NUM_SLOTS-1:0] free;
    free = ~act;
    return free & (~free + NUM_SLOTS'(1));
  endfunction

  assign fire_edge   = fire_btn & ~fire_prev_q;
  assign p_pick_slot = lowest_free(p_active_q);
  assign a_pick_slot = lowest_free(a_active_q);
  assign lfsr_low    = lfsr_q[3:0];
  assign pick_calc   = (lfsr_low >= COLS) ? (lfsr_low - COLS) : lfsr_low;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | fire_edge;
    cooldown_d = cooldown_q;
    timer_d    = timer_q;
    lfsr_d     = lfsr_q;
    pick_d     = pick_q;
    p_active_d = p_active_q & ~p_done;
    a_active_d = a_active_q & ~a_done;
    p_launch_d = '0;
    a_launch_d = '0;
    launch_x_d = launch_x_q;

    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d = P_CHECK;
          if (cooldown_q != '0) cooldown_d = cooldown_q - CD_W'(1);
        end
      end
      P_CHECK: begin
        state_d = A_CHECK;
        // Shooter column is chosen one cycle ahead so alien_x has settled by A_CHECK.
        pick_d  = pick_calc;
        if (pending_q && (cooldown_q == '0) && (p_pick_slot != '0)) begin
          p_launch_d = p_pick_slot;
          p_active_d = (p_active_q & ~p_done) | p_pick_slot;
          launch_x_d = player_x;
          cooldown_d = CD_W'(P_COOLDOWN);
          pending_d  = 1'b0;
        end
      end
      A_CHECK: begin
        state_d = IDLE;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (timer_q == '0) begin
          // The attempt is consumed even when every alien slot is busy.
          timer_d = TM_W'(A_PERIOD - 1);
          if (a_pick_slot != '0) begin
            a_launch_d = a_pick_slot;
            a_active_d = (a_active_q & ~a_done) | a_pick_slot;
            launch_x_d = alien_x;
          end
        end else begin
          timer_d = timer_q - TM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!game_enable) begin
      state_d    = IDLE;
      pending_d  = 1'b0;
      cooldown_d = '0;
      timer_d    = TM_W'(A_PERIOD - 1);
      p_active_d = '0;
      a_active_d = '0;
      p_launch_d = '0;
      a_launch_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      fire_prev_q <= 1'b0;
      cooldown_q  <= '0;
      timer_q     <= TM_W'(A_PERIOD - 1);
      lfsr_q      <= LFSR_SEED;
      pick_q      <= '0;
      p_active_q  <= '0;
      a_active_q  <= '0;
      p_launch_q  <= '0;
      a_launch_q  <= '0;
      launch_x_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      fire_prev_q <= fire_btn;
      cooldown_q  <= cooldown_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      pick_q      <= pick_d;
      p_active_q  <= p_active_d;
      a_active_q  <= a_active_d;
      p_launch_q  <= p_launch_d;
      a_launch_q  <= a_launch_d;
      launch_x_q  <= launch_x_d;
    end
  end

  assign alien_pick = pick_q;
  assign p_launch   = p_launch_q;
  assign a_launch   = a_launch_q;
  assign launch_x   = launch_x_q;
  assign p_active   = p_active_q;
  assign a_active   = a_active_q;

endmodule

// File: tb/tb_rocket_scheduler.sv
// Bench for rocket_scheduler: directed frame scenarios, then random frames, all checked against a frame-level model.
module tb_rocket_scheduler;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          resetN, sof, en, fire;
  logic [10:0]   px, ax;
  logic [NS-1:0] pd, ad;
  logic [3:0]    alien_pick;
  logic [NS-1:0] p_launch, a_launch, p_active, a_active;
  logic [10:0]   launch_x;

  always #5 clk = ~clk;

  rocket_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .game_enable(en),
    .fire_btn(fire), .player_x(px), .alien_x(ax), .p_done(pd), .a_done(ad),
    .alien_pick(alien_pick), .p_launch(p_launch), .a_launch(a_launch),
    .launch_x(launch_x), .p_active(p_active), .a_active(a_active)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: slot occupancy, pending shot, frames of cooldown, frames until alien attempt.
  int         m_p[NS];
  int         m_a[NS];
  int         m_pend, m_cd, m_timer, m_phase, m_prev, m_pick;
  logic [7:0] m_lfsr;
  logic [10:0] m_lx;
  int         exp_pl, exp_al;

  int frame_no;
  int p_lf[$];
  int p_ls[$];
  int a_lf[$];
  int a_ls[$];
  logic [10:0] cur_px, cur_ax;

  function automatic int low_free(input int side);
    for (int i = 0; i < NS; i++) begin
      if (side == 0 && m_p[i] == 0) return i;
      if (side == 1 && m_a[i] == 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] occ(input int side);
    logic [NS-1:0] m;
    m = '0;
    for (int i = 0; i < NS; i++) m[i] = (side == 0) ? (m_p[i] != 0) : (m_a[i] != 0);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_p[i] = 0;
      m_a[i] = 0;
    end
    m_pend = 0; m_cd = 0; m_timer = 29; m_phase = 0; m_prev = 0; m_pick = 0;
    m_lfsr = 8'hA5; m_lx = '0; exp_pl = -1; exp_al = -1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pl"}, p_launch, 0);
    chk({tag, "_al"}, a_launch, 0);
    chk({tag, "_lx"}, launch_x, 0);
    chk({tag, "_pa"}, p_active, 0);
    chk({tag, "_aa"}, a_active, 0);
    chk({tag, "_pick"}, alien_pick, 0);
  endtask

  task automatic hard_reset();
    resetN = 1'b0; sof = 0; en = 0; fire = 0; pd = '0; ad = '0; px = '0; ax = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_zero("reset");
    resetN = 1'b1;
  endtask

  task automatic step(input logic sof_i, input logic fire_i, input logic en_i,
                      input logic [NS-1:0] pd_i, input logic [NS-1:0] ad_i);
    int old;
    int fr;
    int edge_seen;
    int served;
    logic [NS-1:0] epl, eal;
    sof = sof_i; fire = fire_i; en = en_i; pd = pd_i; ad = ad_i; px = cur_px; ax = cur_ax;

    edge_seen = (fire_i && m_prev == 0) ? 1 : 0;
    m_prev = fire_i ? 1 : 0;
    exp_pl = -1; exp_al = -1; served = 0;
    old = m_phase;
    if (old == 1) m_pick = int'(m_lfsr & 8'h0F) % 10;
    if (old == 2) m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    if (!en_i) begin
      for (int i = 0; i < NS; i++) begin
        m_p[i] = 0;
        m_a[i] = 0;
      end
      m_pend = 0; m_cd = 0; m_timer = 29; m_phase = 0;
    end else begin
      if (old == 0 && sof_i) begin
        if (m_cd > 0) m_cd--;
        m_phase = 1;
      end else if (old == 1) begin
        fr = low_free(0);
        if (m_pend != 0 && m_cd == 0 && fr >= 0) begin
          exp_pl = fr; m_lx = cur_px; m_cd = 8; m_pend = 0; served = 1;
        end
        m_phase = 2;
      end else if (old == 2) begin
        if (m_timer == 0) begin
          m_timer = 29;
          fr = low_free(1);
          if (fr >= 0) begin
            exp_al = fr; m_lx = cur_ax;
          end
        end else begin
          m_timer--;
        end
        m_phase = 0;
      end
      if (!served && edge_seen != 0) m_pend = 1;
      for (int i = 0; i < NS; i++) begin
        if (pd_i[i]) m_p[i] = 0;
        if (ad_i[i]) m_a[i] = 0;
      end
      if (exp_pl >= 0) m_p[exp_pl] = 1;
      if (exp_al >= 0) m_a[exp_al] = 1;
    end

    @(posedge clk);
    #1;
    epl = '0; eal = '0;
    if (exp_pl >= 0) epl[exp_pl] = 1'b1;
    if (exp_al >= 0) eal[exp_al] = 1'b1;
    chk("p_launch", p_launch, epl);
    chk("a_launch", a_launch, eal);
    chk("launch_x", launch_x, m_lx);
    chk("p_active", p_active, occ(0));
    chk("a_active", a_active, occ(1));
    chk("alien_pick", alien_pick, m_pick);
    chk("pick_range", (alien_pick <= 4'd9), 1);
    for (int i = 0; i < NS; i++) begin
      if (p_launch[i]) begin
        p_lf.push_back(frame_no); p_ls.push_back(i);
        $display("frame %0d player launch slot %0d x=%0d", frame_no, i, launch_x);
      end
      if (a_launch[i]) begin
        a_lf.push_back(frame_no); a_ls.push_back(i);
        $display("frame %0d alien launch slot %0d x=%0d pick=%0d", frame_no, i, launch_x, alien_pick);
      end
    end
  endtask

  // An 8-cycle frame: SOF on cycle 0, fire held on cycles 4-5, done masks on chosen cycles.
  task automatic frame(input bit fire_f, input logic [NS-1:0] pd_m, input int pd_c,
                       input logic [NS-1:0] ad_m, input int ad_c, input bit en_f, input int rst_c);
    frame_no++;
    for (int c = 0; c < 8; c++) begin
      if (c == rst_c) begin
        sof = 0; fire = 0; pd = '0; ad = '0;
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        resetN = 1'b1;
        return;
      end
      step(c == 0, fire_f && (c == 4 || c == 5), en_f,
           (c == pd_c) ? pd_m : '0, (c == ad_c) ? ad_m : '0);
    end
  endtask

  int a_cnt;

  initial begin
    cur_px = 11'd320; cur_ax = 11'd100;
    hard_reset();
    frame_no = 0;

    // Fire edge ahead of the first frame.
    step(0, 1, 1, '0, '0);
    step(0, 0, 1, '0, '0);
    frame(1, '0, -1, '0, -1, 1, -1);
    chk("f1_p_active", p_active, 3'b001);
    chk("f1_first_frame", p_lf[0], 1);
    for (int f = 2; f <= 25; f++) frame(1, '0, -1, '0, -1, 1, -1);
    chk("f25_full", p_active, 3'b111);
    chk("f25_count", p_lf.size(), 3);
    chk("f9_frame", p_lf[1], 9);
    chk("f17_frame", p_lf[2], 17);
    chk("f17_slot", p_ls[2], 2);
    frame(1, 3'b010, 5, '0, -1, 1, -1);
    frame(1, '0, -1, '0, -1, 1, -1);
    chk("f27_frame", p_lf[3], 27);
    chk("f27_slot", p_ls[3], 1);
    for (int f = 28; f <= 35; f++) frame(1, '0, -1, '0, -1, 1, -1);
    frame(1, 3'b001, 1, '0, -1, 1, -1);
    chk("f36_no_launch", p_lf.size(), 4);
    frame(1, '0, -1, '0, -1, 1, -1);
    chk("f37_frame", p_lf[4], 37);
    chk("f37_slot", p_ls[4], 0);
    for (int f = 38; f <= 60; f++) frame(1, '0, -1, '0, -1, 1, -1);
    chk("a_first_frame", a_lf[0], 30);
    chk("a_second_frame", a_lf[1], 60);
    chk("a_second_slot", a_ls[1], 1);
    chk("f60_p_active", p_active, 3'b111);
    chk("f60_a_active", a_active, 3'b011);

    frame(1, '0, -1, '0, -1, 0, -1);
    chk("dis_p_active", p_active, 0);
    chk("dis_a_active", a_active, 0);
    step(0, 1, 1, '0, '0);
    step(0, 0, 1, '0, '0);
    frame(0, '0, -1, '0, -1, 1, -1);
    chk("reen_frame", p_lf[p_lf.size()-1], 62);
    chk("reen_slot", p_ls[p_ls.size()-1], 0);

    // Reset arriving during an A_CHECK that would launch an alien rocket.
    hard_reset();
    frame_no = 0;
    for (int f = 1; f <= 29; f++) frame(0, '0, -1, '0, -1, 1, -1);
    a_cnt = a_lf.size();
    frame(0, '0, -1, '0, -1, 1, 2);
    for (int f = 31; f <= 33; f++) frame(0, '0, -1, '0, -1, 1, -1);
    chk("rst_no_a_launch", a_lf.size(), a_cnt);

    for (int f = 0; f < 250; f++) begin
      cur_px = 11'($urandom_range(0, 2047));
      cur_ax = 11'($urandom_range(0, 2047));
      frame($urandom_range(0, 1) == 1, NS'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            NS'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom_range(0, 19) != 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
